// File: rtl/mc_controller_if.sv
// mc_controller_if: control bus between the IR, memories, datapath and mc_controller
//   master: controller side (consumes opcode/funct/readies, drives strobes/selects/state)
//   slave : IR/memory/datapath side
interface mc_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       imem_ready;
    logic       dmem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       imem_read;
    logic       dmem_read;
    logic       dmem_write;
    logic       reg_write;
    logic [2:0] alu_control;
    logic       alu_src;
    logic [2:0] ext_control;
    logic [2:0] mem2reg;
    logic [1:0] reg_dst;
    logic [2:0] npc_control;
    logic [1:0] branch_type;
    logic       md_start;
    logic       md_busy;
    logic       illegal;
    logic [2:0] state;
    modport master (
        input  opcode, funct, imem_ready, dmem_ready,
        output pc_write, ir_write, imem_read, dmem_read, dmem_write, reg_write,
        output alu_control, alu_src, ext_control, mem2reg, reg_dst, npc_control, branch_type,
        output md_start, md_busy, illegal, state
    );
    modport slave (
        output opcode, funct, imem_ready, dmem_ready,
        input  pc_write, ir_write, imem_read, dmem_read, dmem_write, reg_write,
        input  alu_control, alu_src, ext_control, mem2reg, reg_dst, npc_control, branch_type,
        input  md_start, md_busy, illegal, state
    );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/MD) with memory stalls
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.master : opcode/funct/imem_ready/dmem_ready in; strobes, selects, md_start/md_busy,
//                illegal and debug state out (all outputs combinational from state + IR)
module mc_controller #(
    parameter int MD_EN      = 1,
    parameter int MD_LATENCY = 5,
    parameter int CNT_W      = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mc_controller_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_MD     = 3'd6
    } state_t;
    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [5:0] w_op, w_fn;
    logic w_r, w_md_en, w_sel;
    logic w_add, w_sub, w_xor, w_sll, w_jr, w_jalr, w_mult, w_div, w_mfhi, w_mflo;
    logic w_ori, w_addi, w_lui, w_lw, w_lb, w_sw, w_beq, w_bgtz, w_boez, w_j, w_jal;
    logic w_md, w_ld, w_br, w_legal, w_alu_src;
    logic [2:0] w_alu, w_ext, w_m2r, w_npc;
    logic [1:0] w_dst, w_bt;
    assign w_op    = bus.opcode;
    assign w_fn    = bus.funct;
    assign w_md_en = MD_EN != 0;
    assign w_r     = w_op == 6'b000000;
    assign w_add   = w_r && w_fn == 6'b100000;
    assign w_sub   = w_r && w_fn == 6'b100010;
    assign w_xor   = w_r && w_fn == 6'b100110;
    assign w_sll   = w_r && w_fn == 6'b000000;
    assign w_jr    = w_r && w_fn == 6'b001000;
    assign w_jalr  = w_r && w_fn == 6'b001001;
    assign w_mult  = w_md_en && w_r && w_fn == 6'b011000;
    assign w_div   = w_md_en && w_r && w_fn == 6'b011010;
    assign w_mfhi  = w_md_en && w_r && w_fn == 6'b010000;
    assign w_mflo  = w_md_en && w_r && w_fn == 6'b010010;
    assign w_ori   = w_op == 6'b001101;
    assign w_addi  = w_op == 6'b001000;
    assign w_lui   = w_op == 6'b001111;
    assign w_lw    = w_op == 6'b100011;
    assign w_lb    = w_op == 6'b100000;
    assign w_sw    = w_op == 6'b101011;
    assign w_beq   = w_op == 6'b000100;
    assign w_bgtz  = w_op == 6'b000111;
    assign w_boez  = w_op == 6'b101100;
    assign w_j     = w_op == 6'b000010;
    assign w_jal   = w_op == 6'b000011;
    assign w_md    = w_mult | w_div;
    assign w_ld    = w_lw | w_lb;
    assign w_br    = w_beq | w_bgtz | w_boez;
    assign w_legal = w_add | w_sub | w_xor | w_sll | w_jr | w_jalr | w_md | w_mfhi | w_mflo |
                     w_ori | w_addi | w_lui | w_ld | w_sw | w_br | w_j | w_jal;
    assign w_alu     = (w_sub | w_br) ? 3'b001 : w_xor ? 3'b010 : w_ori ? 3'b011 : w_sll ? 3'b100 : 3'b000;
    assign w_alu_src = w_ori | w_addi | w_lui | w_ld | w_sw;
    assign w_ext     = w_lui ? 3'b010 : (w_addi | w_ld | w_sw | w_br) ? 3'b001 : 3'b000;
    assign w_m2r     = w_lw ? 3'b001 : w_lui ? 3'b010 : (w_jal | w_jalr) ? 3'b011 :
                       w_lb ? 3'b100 : w_mfhi ? 3'b101 : w_mflo ? 3'b110 : 3'b000;
    assign w_dst     = w_jal ? 2'b10 : w_r ? 2'b01 : 2'b00;
    assign w_npc     = w_br ? 3'b001 : (w_j | w_jal) ? 3'b010 : (w_jr | w_jalr) ? 3'b100 : 3'b000;
    assign w_bt      = w_beq ? 2'b01 : w_bgtz ? 2'b10 : w_boez ? 2'b11 : 2'b00;
    // decoded selects are only presented once the IR holds the current instruction
    assign w_sel     = r_state != S_IDLE && r_state != S_FETCH;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // countdown loaded with LATENCY-1 so that the exit cycle is the cycle counter==0
            if (r_state == S_EXEC && w_md)
                r_cnt <= CNT_W'(MD_LATENCY - 1);
            else if (r_state == S_MD && r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
        end
    end
    always_comb begin
        w_next          = r_state;
        bus.pc_write    = 1'b0;
        bus.ir_write    = 1'b0;
        bus.imem_read   = 1'b0;
        bus.dmem_read   = 1'b0;
        bus.dmem_write  = 1'b0;
        bus.reg_write   = 1'b0;
        bus.md_start    = 1'b0;
        bus.md_busy     = 1'b0;
        bus.illegal     = 1'b0;
        bus.npc_control = 3'b000;
        bus.alu_control = w_sel ? w_alu : 3'b000;
        bus.alu_src     = w_sel & w_alu_src;
        bus.ext_control = w_sel ? w_ext : 3'b000;
        bus.mem2reg     = w_sel ? w_m2r : 3'b000;
        bus.reg_dst     = w_sel ? w_dst : 2'b00;
        bus.branch_type = w_sel ? w_bt : 2'b00;
        bus.state       = r_state;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                bus.imem_read = 1'b1;
                bus.ir_write  = bus.imem_ready;
                bus.pc_write  = bus.imem_ready;
                w_next        = bus.imem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                bus.illegal = !w_legal;
                w_next      = w_legal ? S_EXEC : S_FETCH;
            end
            S_EXEC: begin
                bus.npc_control = w_npc;
                bus.pc_write    = w_br | w_j | w_jal | w_jr | w_jalr;
                bus.md_start    = w_md;
                w_next          = w_md ? S_MD : (w_ld | w_sw) ? S_MEM : (w_br | w_j | w_jr) ? S_FETCH : S_WB;
            end
            S_MEM: begin
                bus.dmem_read  = w_ld;
                bus.dmem_write = w_sw;
                w_next         = !bus.dmem_ready ? S_MEM : w_ld ? S_WB : S_FETCH;
            end
            S_WB: begin
                bus.reg_write = 1'b1;
                w_next        = S_FETCH;
            end
            S_MD: begin
                bus.md_busy = 1'b1;
                w_next      = r_cnt == '0 ? S_FETCH : S_MD;
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: decode table + randomized instruction stream against a cycle-sequence model
module tb_mc_controller;
    localparam int C_ALU = 0, C_BR = 1, C_JMP = 2, C_LINK = 3, C_LD = 4, C_ST = 5, C_MD = 6, C_ILL = 7;
    localparam int K_PC = 8, K_IR = 7, K_IMR = 6, K_DMR = 5, K_DMW = 4, K_RW = 3, K_MDS = 2, K_MDB = 1, K_ILL = 0;
    localparam int M_ALU = 1, M_EXT = 2, M_NPC = 4, M_BT = 8, M_M2R = 16, M_DST = 32;
    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         cls;
        bit         md;
        logic [2:0] alu;
        logic       src;
        logic [2:0] ext;
        logic [2:0] m2r;
        logic [1:0] dst;
        logic [2:0] npc;
        logic [1:0] bt;
        int         m;
    } vec_t;
    typedef struct {
        logic       ir;
        logic       dr;
        logic [2:0] st;
        logic [8:0] strb;
        bit         ex;
        bit         wb;
    } step_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic imem_ready = 1'b0, dmem_ready = 1'b0;
    int sel = 0;
    int checks = 0, failures = 0;
    vec_t tbl[24];
    always #5 clk = ~clk;
    mc_controller_if ifa ();
    mc_controller_if ifb ();
    mc_controller_if ifc ();
    assign ifa.opcode = opcode;
    assign ifa.funct = funct;
    assign ifa.imem_ready = imem_ready;
    assign ifa.dmem_ready = dmem_ready;
    assign ifb.opcode = opcode;
    assign ifb.funct = funct;
    assign ifb.imem_ready = imem_ready;
    assign ifb.dmem_ready = dmem_ready;
    assign ifc.opcode = opcode;
    assign ifc.funct = funct;
    assign ifc.imem_ready = imem_ready;
    assign ifc.dmem_ready = dmem_ready;
    mc_controller #(.MD_EN(1), .MD_LATENCY(5), .CNT_W(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    mc_controller #(.MD_EN(0), .MD_LATENCY(5), .CNT_W(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    mc_controller #(.MD_EN(1), .MD_LATENCY(1), .CNT_W(4)) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
    logic [28:0] pa, pb, pc_, ob;
    assign pa = {ifa.state, ifa.pc_write, ifa.ir_write, ifa.imem_read, ifa.dmem_read, ifa.dmem_write,
                 ifa.reg_write, ifa.md_start, ifa.md_busy, ifa.illegal, ifa.alu_control, ifa.alu_src,
                 ifa.ext_control, ifa.mem2reg, ifa.reg_dst, ifa.npc_control, ifa.branch_type};
    assign pb = {ifb.state, ifb.pc_write, ifb.ir_write, ifb.imem_read, ifb.dmem_read, ifb.dmem_write,
                 ifb.reg_write, ifb.md_start, ifb.md_busy, ifb.illegal, ifb.alu_control, ifb.alu_src,
                 ifb.ext_control, ifb.mem2reg, ifb.reg_dst, ifb.npc_control, ifb.branch_type};
    assign pc_ = {ifc.state, ifc.pc_write, ifc.ir_write, ifc.imem_read, ifc.dmem_read, ifc.dmem_write,
                  ifc.reg_write, ifc.md_start, ifc.md_busy, ifc.illegal, ifc.alu_control, ifc.alu_src,
                  ifc.ext_control, ifc.mem2reg, ifc.reg_dst, ifc.npc_control, ifc.branch_type};
    assign ob = (sel == 0) ? pa : (sel == 1) ? pb : pc_;
    logic [2:0] o_state, o_alu, o_ext, o_m2r, o_npc;
    logic [8:0] o_strb;
    logic       o_src;
    logic [1:0] o_dst, o_bt;
    assign o_state = ob[28:26];
    assign o_strb  = ob[25:17];
    assign o_alu   = ob[16:14];
    assign o_src   = ob[13];
    assign o_ext   = ob[12:10];
    assign o_m2r   = ob[9:7];
    assign o_dst   = ob[6:5];
    assign o_npc   = ob[4:2];
    assign o_bt    = ob[1:0];
    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input int cls, input bit md,
                                input logic [2:0] alu, input logic src, input logic [2:0] ext,
                                input logic [2:0] m2r, input logic [1:0] dst, input logic [2:0] npc,
                                input logic [1:0] bt, input int m);
        vec_t v;
        v.op = op; v.fn = fn; v.cls = cls; v.md = md; v.alu = alu; v.src = src; v.ext = ext;
        v.m2r = m2r; v.dst = dst; v.npc = npc; v.bt = bt; v.m = m;
        return v;
    endfunction
    function automatic logic [8:0] b(input int k);
        return 9'(1 << k);
    endfunction
    function automatic step_t stp(input logic ir, input logic dr, input logic [2:0] st,
                                  input logic [8:0] strb, input bit ex, input bit wb);
        step_t s;
        s.ir = ir; s.dr = dr; s.st = st; s.strb = strb; s.ex = ex; s.wb = wb;
        return s;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (dut%0d op=%b fn=%b t=%0t): got %0h expected %0h", nm, sel, opcode, funct, $time, act, exp);
        end
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        @(negedge clk);
        chk("reset_state", 32'(o_state), 0);
        chk("reset_strobes", 32'(o_strb), 0);
        chk("reset_selects", 32'(ob[16:0]), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_state", 32'(o_state), 0);
        chk("idle_strobes", 32'(o_strb), 0);
        @(posedge clk); #1;
    endtask
    // expands one instruction into its expected per-cycle state/strobe sequence and plays it
    task automatic run_instr(input vec_t v, input int ni, input int nd, input int lat, input bit md_en);
        step_t q[$];
        int cls;
        logic [8:0] ms;
        cls = (v.md && !md_en) ? C_ILL : v.cls;
        opcode = v.op;
        funct = (v.op == 6'b000000) ? v.fn : 6'($urandom);
        for (int i = 0; i < ni; i++) q.push_back(stp(1'b0, 1'($urandom), 3'd1, b(K_IMR), 0, 0));
        q.push_back(stp(1'b1, 1'($urandom), 3'd1, b(K_IMR) | b(K_IR) | b(K_PC), 0, 0));
        q.push_back(stp(1'($urandom), 1'($urandom), 3'd2, cls == C_ILL ? b(K_ILL) : 9'd0, 0, 0));
        if (cls != C_ILL) begin
            q.push_back(stp(1'($urandom), 1'($urandom), 3'd3,
                            ((cls == C_BR || cls == C_JMP || cls == C_LINK) ? b(K_PC) : 9'd0) |
                            (cls == C_MD ? b(K_MDS) : 9'd0), 1, 0));
            if (cls == C_MD)
                for (int i = 0; i < lat; i++) q.push_back(stp(1'($urandom), 1'($urandom), 3'd6, b(K_MDB), 0, 0));
            if (cls == C_LD || cls == C_ST) begin
                ms = cls == C_LD ? b(K_DMR) : b(K_DMW);
                for (int i = 0; i < nd; i++) q.push_back(stp(1'($urandom), 1'b0, 3'd4, ms, 0, 0));
                q.push_back(stp(1'($urandom), 1'b1, 3'd4, ms, 0, 0));
            end
            if (cls == C_ALU || cls == C_LINK || cls == C_LD)
                q.push_back(stp(1'($urandom), 1'($urandom), 3'd5, b(K_RW), 0, 1));
        end
        foreach (q[i]) begin
            imem_ready = q[i].ir;
            dmem_ready = q[i].dr;
            @(negedge clk);
            chk("state", 32'(o_state), 32'(q[i].st));
            chk("strobes", 32'(o_strb), 32'(q[i].strb));
            if (q[i].ex) begin
                if ((v.m & M_ALU) != 0) begin
                    chk("alu_control", 32'(o_alu), 32'(v.alu));
                    chk("alu_src", 32'(o_src), 32'(v.src));
                end
                if ((v.m & M_EXT) != 0) chk("ext_control", 32'(o_ext), 32'(v.ext));
                if ((v.m & M_NPC) != 0) chk("npc_control", 32'(o_npc), 32'(v.npc));
                if ((v.m & M_BT) != 0) chk("branch_type", 32'(o_bt), 32'(v.bt));
            end
            if (q[i].wb) begin
                if ((v.m & M_M2R) != 0) chk("mem2reg", 32'(o_m2r), 32'(v.m2r));
                if ((v.m & M_DST) != 0) chk("reg_dst", 32'(o_dst), 32'(v.dst));
            end
            @(posedge clk); #1;
        end
    endtask
    initial begin
        tbl[0]  = mk(6'b000000, 6'b100000, C_ALU,  0, 3'b000, 1'b0, 3'b000, 3'b000, 2'b01, 3'b000, 2'b00, M_ALU | M_M2R | M_DST);
        tbl[1]  = mk(6'b000000, 6'b100010, C_ALU,  0, 3'b001, 1'b0, 3'b000, 3'b000, 2'b01, 3'b000, 2'b00, M_ALU | M_M2R | M_DST);
        tbl[2]  = mk(6'b000000, 6'b100110, C_ALU,  0, 3'b010, 1'b0, 3'b000, 3'b000, 2'b01, 3'b000, 2'b00, M_ALU | M_M2R | M_DST);
        tbl[3]  = mk(6'b000000, 6'b000000, C_ALU,  0, 3'b100, 1'b0, 3'b000, 3'b000, 2'b01, 3'b000, 2'b00, M_ALU | M_M2R | M_DST);
        tbl[4]  = mk(6'b000000, 6'b001000, C_JMP,  0, 3'b000, 1'b0, 3'b000, 3'b000, 2'b00, 3'b100, 2'b00, M_NPC);
        tbl[5]  = mk(6'b000000, 6'b001001, C_LINK, 0, 3'b000, 1'b0, 3'b000, 3'b011, 2'b01, 3'b100, 2'b00, M_NPC | M_M2R | M_DST);
        tbl[6]  = mk(6'b000000, 6'b011000, C_MD,   1, 3'b000, 1'b0, 3'b000, 3'b000, 2'b00, 3'b000, 2'b00, 0);
        tbl[7]  = mk(6'b000000, 6'b011010, C_MD,   1, 3'b000, 1'b0, 3'b000, 3'b000, 2'b00, 3'b000, 2'b00, 0);
        tbl[8]  = mk(6'b000000, 6'b010000, C_ALU,  1, 3'b000, 1'b0, 3'b000, 3'b101, 2'b01, 3'b000, 2'b00, M_M2R | M_DST);
        tbl[9]  = mk(6'b000000, 6'b010010, C_ALU,  1, 3'b000, 1'b0, 3'b000, 3'b110, 2'b01, 3'b000, 2'b00, M_M2R | M_DST);
        tbl[10] = mk(6'b001101, 6'b000000, C_ALU,  0, 3'b011, 1'b1, 3'b000, 3'b000, 2'b00, 3'b000, 2'b00, M_ALU | M_EXT | M_M2R | M_DST);
        tbl[11] = mk(6'b001000, 6'b000000, C_ALU,  0, 3'b000, 1'b1, 3'b001, 3'b000, 2'b00, 3'b000, 2'b00, M_ALU | M_EXT | M_M2R | M_DST);
        tbl[12] = mk(6'b001111, 6'b000000, C_ALU,  0, 3'b000, 1'b1, 3'b010, 3'b010, 2'b00, 3'b000, 2'b00, M_EXT | M_M2R | M_DST);
        tbl[13] = mk(6'b100011, 6'b000000, C_LD,   0, 3'b000, 1'b1, 3'b001, 3'b001, 2'b00, 3'b000, 2'b00, M_ALU | M_EXT | M_M2R | M_DST);
        tbl[14] = mk(6'b100000, 6'b000000, C_LD,   0, 3'b000, 1'b1, 3'b001, 3'b100, 2'b00, 3'b000, 2'b00, M_ALU | M_EXT | M_M2R | M_DST);
        tbl[15] = mk(6'b101011, 6'b000000, C_ST,   0, 3'b000, 1'b1, 3'b001, 3'b000, 2'b00, 3'b000, 2'b00, M_ALU | M_EXT);
        tbl[16] = mk(6'b000100, 6'b000000, C_BR,   0, 3'b000, 1'b0, 3'b001, 3'b000, 2'b00, 3'b001, 2'b01, M_EXT | M_NPC | M_BT);
        tbl[17] = mk(6'b000111, 6'b000000, C_BR,   0, 3'b000, 1'b0, 3'b001, 3'b000, 2'b00, 3'b001, 2'b10, M_EXT | M_NPC | M_BT);
        tbl[18] = mk(6'b101100, 6'b000000, C_BR,   0, 3'b000, 1'b0, 3'b001, 3'b000, 2'b00, 3'b001, 2'b11, M_EXT | M_NPC | M_BT);
        tbl[19] = mk(6'b000010, 6'b000000, C_JMP,  0, 3'b000, 1'b0, 3'b000, 3'b000, 2'b00, 3'b010, 2'b00, M_NPC);
        tbl[20] = mk(6'b000011, 6'b000000, C_LINK, 0, 3'b000, 1'b0, 3'b000, 3'b011, 2'b10, 3'b010, 2'b00, M_NPC | M_M2R | M_DST);
        tbl[21] = mk(6'b111111, 6'b000000, C_ILL,  0, 3'b000, 1'b0, 3'b000, 3'b000, 2'b00, 3'b000, 2'b00, 0);
        tbl[22] = mk(6'b000000, 6'b111111, C_ILL,  0, 3'b000, 1'b0, 3'b000, 3'b000, 2'b00, 3'b000, 2'b00, 0);
        tbl[23] = mk(6'b000001, 6'b000000, C_ILL,  0, 3'b000, 1'b0, 3'b000, 3'b000, 2'b00, 3'b000, 2'b00, 0);
        sel = 0;
        do_reset();
        foreach (tbl[i]) run_instr(tbl[i], 0, 0, 5, 1);
        run_instr(tbl[13], 1, 3, 5, 1);
        repeat (150) run_instr(tbl[$urandom_range(0, 23)], $urandom_range(0, 2), $urandom_range(0, 3), 5, 1);
        sel = 1;
        do_reset();
        foreach (tbl[i]) run_instr(tbl[i], 0, 0, 5, 0);
        sel = 2;
        do_reset();
        run_instr(tbl[6], 0, 0, 1, 1);
        run_instr(tbl[7], 1, 0, 1, 1);
        run_instr(tbl[10], 0, 0, 1, 1);
        sel = 0;
        do_reset();
        opcode = 6'b101011;
        funct = 6'b000000;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("sw_in_mem_state", 32'(o_state), 4);
        chk("sw_in_mem_dmem_write", 32'(o_strb), 32'(b(K_DMW)));
        rst_n = 1'b0;
        #1;
        chk("async_reset_state", 32'(o_state), 0);
        chk("async_reset_strobes", 32'(o_strb), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", 32'(o_state), 0);
        @(posedge clk); #1;
        run_instr(tbl[10], 0, 0, 5, 1);
        run_instr(tbl[15], 0, 2, 5, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
